dense_layer_engine: RTL

DENSE_LAYER_ENGINE -- requirements
Module: dense_layer_engine

---
 rtl/nn_pkg.sv | 26 ++
 rtl/dense_layer_engine_mac_lane.sv | 79 +++++++
 rtl/dense_layer_engine.sv | 139 +++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared types and constants for the dense layer engine.
package nn_pkg;

    localparam int DW      = 8;
    localparam int SAT_MAX = 127;
    localparam int SAT_MIN = -128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_QUANT,
        ST_OUT
    } nn_state_e;

    // Address width for a range of `value` entries; never narrower than 1 bit.
    function automatic int clog2(input int unsigned value);
        int r;
        r = 0;
        while ((32'd1 << r) < value) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/dense_layer_engine_mac_lane.sv
// One neuron lane: signed 8x8 multiply-accumulate, then requantise,
// optional ReLU at the zero point, saturate to int8 and register.
module mac_lane
    import nn_pkg::*;
#(
    parameter int          ACC_W   = 32,
    parameter int unsigned M       = 256,
    parameter int          S_SHIFT = 8,
    parameter int          Z       = 0,
    parameter int          RELU    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 acc_en,
    input  logic                 quant_en,
    input  logic signed [DW-1:0] in_data,
    input  logic signed [DW-1:0] w_data,
    output logic signed [DW-1:0] result
);

    localparam int QW = ACC_W + 17;
    localparam logic signed [QW-1:0] M_EXT   = QW'(M & 32'h0000_FFFF);
    localparam logic signed [QW-1:0] RND     = QW'(64'd1 << (S_SHIFT - 1));
    localparam logic signed [QW-1:0] Z_EXT   = QW'(Z);
    localparam logic signed [QW-1:0] MAX_EXT = QW'(SAT_MAX);
    localparam logic signed [QW-1:0] MIN_EXT = QW'(SAT_MIN);

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [DW-1:0]    res_q, res_d;
    logic signed [2*DW-1:0]  mul;
    logic signed [QW-1:0]    prod, scaled, y, y_relu;

    // Accumulator update: clear on a new pass, add the lane product when enabled.
    always_comb begin
        mul   = in_data * w_data;
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (acc_en) begin
            acc_d = acc_q + ACC_W'(mul);
        end
    end

    // Requantise at full width so acc*M plus rounding never overflows.
    always_comb begin
        prod   = QW'(acc_q) * M_EXT;
        scaled = (prod + RND) >>> S_SHIFT;
        y      = scaled + Z_EXT;
        y_relu = y;
        if (RELU != 0 && y < Z_EXT) begin
            y_relu = Z_EXT;
        end
        res_d = res_q;
        if (quant_en) begin
            if (y_relu > MAX_EXT) begin
                res_d = DW'(SAT_MAX);
            end else if (y_relu < MIN_EXT) begin
                res_d = DW'(SAT_MIN);
            end else begin
                res_d = y_relu[DW-1:0];
            end
        end
    end

    // Lane state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            res_q <= '0;
        end else begin
            acc_q <= acc_d;
            res_q <= res_d;
        end
    end

    assign result = res_q;

endmodule

// File: rtl/dense_layer_engine.sv
// Dense layer engine: streams N_IN activation/weight rows into N_LANES
// parallel MAC lanes, requantises, then emits one int8 result per lane
// over a valid/ready stream.
module dense_layer_engine
    import nn_pkg::*;
#(
    parameter int          N_LANES = 28,
    parameter int          N_IN    = 784,
    parameter int          ACC_W   = 32,
    parameter int unsigned M       = 256,
    parameter int          S_SHIFT = 8,
    parameter int          Z       = 0,
    parameter int          RELU    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [clog2(N_IN)-1:0]        in_addr,
    input  logic signed [DW-1:0]          in_data,
    output logic [clog2(N_IN)-1:0]        w_addr,
    input  logic [DW*N_LANES-1:0]         w_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [clog2(N_LANES)-1:0]     out_idx,
    output logic signed [DW-1:0]          out_data
);

    localparam int AW = clog2(N_IN);
    localparam int IW = clog2(N_LANES);

    nn_state_e            state_q, state_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [IW-1:0]        j_q, j_d;
    logic                 issue_q, issue_d;
    logic                 done_q, done_d;
    logic                 clear;
    logic                 quant_en;
    logic signed [DW-1:0] lane_res [N_LANES];

    // Next-state logic: the address counter doubles as the row index i,
    // so it naturally holds its last value outside RUN.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        j_d      = j_q;
        done_d   = 1'b0;
        clear    = 1'b0;
        quant_en = 1'b0;
        issue_d  = (state_q == ST_RUN);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    clear   = 1'b1;
                    addr_d  = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (addr_q == AW'(N_IN - 1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            ST_DRAIN: begin
                state_d = ST_QUANT;
            end
            ST_QUANT: begin
                quant_en = 1'b1;
                j_d      = '0;
                state_d  = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    if (j_q == IW'(N_LANES - 1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        j_d = j_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            j_q     <= '0;
            issue_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            j_q     <= j_d;
            issue_q <= issue_d;
            done_q  <= done_d;
        end
    end

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        mac_lane #(
            .ACC_W   (ACC_W),
            .M       (M),
            .S_SHIFT (S_SHIFT),
            .Z       (Z),
            .RELU    (RELU)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .clear    (clear),
            .acc_en   (issue_q),
            .quant_en (quant_en),
            .in_data  (in_data),
            .w_data   (w_data[DW*k +: DW]),
            .result   (lane_res[k])
        );
    end

    // Output stream selection.
    always_comb begin
        out_data = lane_res[j_q];
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign out_valid = (state_q == ST_OUT);
    assign out_idx   = j_q;
    assign in_addr   = addr_q;
    assign w_addr    = addr_q;

endmodule
